// File: rtl/pipe_exe_mdu.sv
// EXE-stage iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the front end while busy.
module pipe_exe_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             ewhi,
    input  logic             ewlo,
    input  logic             eflush,
    output logic             mdu_stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div, neg_q, neg_r;

    logic               start_ok, div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign start_ok = (state == IDLE) && estart && !eflush;
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mdu_stall = 1'b0;
        case (state)
            IDLE: if (start_ok) begin
                state_nx  = CALC;
                mdu_stall = 1'b1;
            end
            CALC: if (eflush) begin
                state_nx = IDLE;
            end else begin
                mdu_stall = 1'b1;
                if (count == '0) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divide by zero keeps the raw dividend: a zero divisor then yields all-ones quotient
    // and the original dividend as remainder straight out of the restoring loop.
    always_comb begin
        div_op = eop[1];
        b_neg  = !eop[0] && eb[WIDTH-1];
        a_neg  = !eop[0] && ea[WIDTH-1] && !(div_op && eb == '0);
        a_mag  = a_neg ? -ea : ea;
        b_mag  = b_neg ? -eb : eb;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opb};
        div_next  = div_trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_s    = neg_q ? -acc : acc;
        quo_s     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        is_div <= div_op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        count  <= CW'(WIDTH - 1);
                        acc    <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
                        opb    <= div_op ? b_mag : a_mag;
                    end else if (!estart && !eflush) begin
                        if (ewhi) hi <= ea;
                        if (ewlo) lo <= ea;
                    end
                end
                CALC: if (!eflush) begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count - 1'b1;
                end
                DONE: if (!eflush) begin
                    if (is_div) begin
                        lo <= quo_s;
                        hi <= rem_s;
                    end else begin
                        lo <= prod_s[WIDTH-1:0];
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_exe_mdu.sv
// Directed bench for pipe_exe_mdu: hand-computed HI/LO results, stall length, flush and reset.
module tb_pipe_exe_mdu;

    logic        clock = 1'b0;
    logic        resetn, estart, ewhi, ewlo, eflush;
    logic [1:0]  eop;
    logic [31:0] ea, eb;
    logic        mdu_stall, busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    pipe_exe_mdu #(.WIDTH(32)) dut (
        .clock(clock), .resetn(resetn), .estart(estart), .eop(eop),
        .ea(ea), .eb(eb), .ewhi(ewhi), .ewlo(ewlo), .eflush(eflush),
        .mdu_stall(mdu_stall), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op and count stalled cycles; with keep=1 estart stays high so the
    // next call lands a fresh op in the cycle after DONE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit keep, output int cycles);
        @(negedge clock);
        estart = 1'b1; eop = op; ea = a; eb = b;
        cycles = 0;
        #1;
        for (int i = 0; i < 100 && mdu_stall; i++) begin
            cycles++;
            @(negedge clock); #1;
        end
        if (!keep) begin
            estart = 1'b0;
            @(negedge clock); #1;
        end
    endtask

    initial begin
        resetn = 1'b0; estart = 1'b0; ewhi = 1'b0; ewlo = 1'b0; eflush = 1'b0;
        eop = 2'b00; ea = '0; eb = '0;
        @(negedge clock); @(negedge clock); #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, mdu_stall}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        resetn = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
        check("multu_stall", cyc, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc);
        check("mult_stall", cyc, 33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd7, 1'b0, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(2'b11, 32'h1234, 32'd0, 1'b0, cyc);
        check("divz_stall", cyc, 33);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h1234);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        @(negedge clock); ewhi = 1'b1; ea = 32'hAAAA;
        @(negedge clock); ewhi = 1'b0; ewlo = 1'b1; ea = 32'h5555;
        @(negedge clock); ewlo = 1'b0; #1;
        check("mthi", hi, 32'hAAAA);
        check("mtlo", lo, 32'h5555);

        @(negedge clock); estart = 1'b1; eflush = 1'b1; eop = 2'b00; ea = 32'd3; eb = 32'd5; #1;
        check("idle_flush_stall", {31'd0, mdu_stall}, 32'd0);
        @(negedge clock); #1;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);

        eflush = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clock);
        eflush = 1'b1; estart = 1'b0; #1;
        check("calc_flush_stall", {31'd0, mdu_stall}, 32'd0);
        @(negedge clock); eflush = 1'b0; #1;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_stall", {31'd0, mdu_stall}, 32'd0);
        check("flush_hi", hi, 32'hAAAA);
        check("flush_lo", lo, 32'h5555);

        run_op(2'b01, 32'd2, 32'd3, 1'b1, cyc);
        check("b2b_stall1", cyc, 33);
        run_op(2'b01, 32'd4, 32'd5, 1'b0, cyc);
        check("b2b_stall2", cyc, 33);
        check("b2b_lo", lo, 32'd20);
        check("b2b_hi", hi, 32'd0);

        @(negedge clock); estart = 1'b1; eop = 2'b01; ea = 32'd9; eb = 32'd9;
        for (int i = 0; i < 6; i++) @(negedge clock);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0; estart = 1'b0; #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, mdu_stall}, 32'd0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_exe_mdu.md
Name: pipe_exe_mdu

Overview:
- Iterative multiply/divide unit in the EXE stage. Consumes operands and control from the decode/execute pipeline register (ea, eb, op/start).
- Drives a stall back toward decode and fetch while it computes, so the D/E register and earlier stages hold. Owns the HI/LO registers.
- Results are read by mfhi/mflo through the hi/lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- estart  in  1  EXE-stage instruction is mult/multu/div/divu
- eop  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
- ea  in  WIDTH  operand A (multiplicand/dividend); also mthi/mtlo data
- eb  in  WIDTH  operand B (multiplier/divisor)
- ewhi  in  1  mthi in EXE: write ea to HI
- ewlo  in  1  mtlo in EXE: write ea to LO
- eflush  in  1  cancel the in-flight operation (exception/redirect)
- mdu_stall  out  1  hold PC, F/D and D/E registers
- busy  out  1  FSM not in IDLE
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, count=0, hi=0, lo=0, internal accumulators=0, mdu_stall=0, busy=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, estart=1: latch |ea| and |eb| into the working registers. Magnitudes are taken for signed ops only; record result sign(s). Set count=WIDTH-1, go to CALC.
- mdu_stall is combinational and equals (IDLE and estart and not eflush) or CALC. The stall is therefore high in the same cycle start is seen.
- CALC: one iteration per cycle.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - count decrements each cycle; when count=0, go to DONE.
- DONE: write results to HI/LO, drop mdu_stall, ignore estart. Next state is IDLE.
  - Mult: HI=upper half, LO=lower half of the product, two's-complement negated if the signs differ (signed op only).
  - Div: LO=quotient, HI=remainder. Signed: quotient negative if the signs differ; remainder takes the sign of the dividend.
- Latency: start cycle plus WIDTH CALC cycles, then DONE. mdu_stall is high for exactly WIDTH+1 cycles. HI/LO are visible in the cycle after DONE.
- Back-to-back MDU ops: the next op enters EXE on the edge leaving DONE and is accepted from IDLE. No re-issue of the same op.
- Divide by zero (eb=0): LO=all ones, HI=ea (original, unsigned-as-given). Still takes full latency.
- Signed overflow (div, ea=0x80000000, eb=0xFFFFFFFF): LO=0x80000000, HI=0.
- eflush in CALC or DONE: return to IDLE next edge, HI/LO unchanged, mdu_stall=0 in that cycle. eflush in IDLE blocks acceptance.
- ewhi/ewlo: take effect only in IDLE with estart=0 and eflush=0, on the clock edge. If both are set, both registers are written. While busy they are ignored (cannot occur legally, since the pipeline is stalled).
- Reset asserted mid-operation: immediate return to the reset values above.
- estart held high throughout CALC: no effect (the D/E register is holding).

Test Plan:
- multu, ea=0xFFFFFFFF, eb=0xFFFFFFFF -> mdu_stall high 33 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- mult, ea=-3 (0xFFFFFFFD), eb=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div, ea=-7, eb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu ea=100, eb=7 -> LO=14, HI=2.
- divu, eb=0, ea=0x1234 -> LO=0xFFFFFFFF, HI=0x1234. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0xAAAA then mtlo 0x5555 in IDLE -> hi=0xAAAA, lo=0x5555. Start mult, assert eflush at CALC cycle 10 -> IDLE next cycle, hi/lo still 0xAAAA/0x5555, stall low.
- Two back-to-back multu (2*3, then 4*5) -> second accepted the cycle after DONE, final LO=20. Assert resetn=0 mid-CALC -> hi=lo=0, busy=0 immediately.
